// File: rtl/cc_race_judge.sv
// Race result judge: snapshots the player scores, scans them for the maximum and shows
// the winner (or a tie) glyph on an 8x8 active-low matrix. Optional blinking: CC_RACE_JUDGE_BLINK_EN.
module cc_race_judge #(
  parameter int NUM_P       = 2,
  parameter int SCORE_W     = 6,
  parameter int HOLD_TICKS  = 8,
  parameter int BLINK_TICKS = 2
) (
  input  logic                       CC_RACE_JUDGE_CLOCK_50,
  input  logic                       CC_RACE_JUDGE_RESET_InLow,
  input  logic                       CC_RACE_JUDGE_Start_In,
  input  logic                       CC_RACE_JUDGE_Tick_In,
  input  logic [NUM_P*SCORE_W-1:0]   CC_RACE_JUDGE_Scores_In,
  output logic [7:0]                 CC_RACE_JUDGE_D0_outBus,
  output logic [7:0]                 CC_RACE_JUDGE_D1_outBus,
  output logic [7:0]                 CC_RACE_JUDGE_D2_outBus,
  output logic [7:0]                 CC_RACE_JUDGE_D3_outBus,
  output logic [7:0]                 CC_RACE_JUDGE_D4_outBus,
  output logic [7:0]                 CC_RACE_JUDGE_D5_outBus,
  output logic [7:0]                 CC_RACE_JUDGE_D6_outBus,
  output logic [7:0]                 CC_RACE_JUDGE_D7_outBus,
  output logic [1:0]                 CC_RACE_JUDGE_Winner_Out,
  output logic                       CC_RACE_JUDGE_Tie_Out,
  output logic                       CC_RACE_JUDGE_Busy_Out,
  output logic                       CC_RACE_JUDGE_Done_Out
);

  localparam int CNT_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [1:0]       LAST_IDX  = 2'(NUM_P - 1);

  if (NUM_P < 2 || NUM_P > 4 || HOLD_TICKS < 1 || BLINK_TICKS < 1) begin : g_cfg_err
    $error("cc_race_judge: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SHOW,
    ST_DONE
  } state_t;

  logic                     clk;
  logic                     rst_n;
  assign clk   = CC_RACE_JUDGE_CLOCK_50;
  assign rst_n = CC_RACE_JUDGE_RESET_InLow;

  state_t                   state_reg;
  logic [NUM_P*SCORE_W-1:0] snap_reg;
  logic [SCORE_W-1:0]       best_reg;
  logic [1:0]               lead_reg;
  logic                     tie_scan_reg;
  logic [1:0]               idx_reg;
  logic [CNT_W-1:0]         tick_cnt_reg;
  logic [1:0]               winner_reg;
  logic                     tie_reg;
  logic                     busy_reg;
  logic                     done_reg;
  logic [63:0]              rows_reg;

`ifdef CC_RACE_JUDGE_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  logic [BLINK_W-1:0]       blink_cnt_reg;
  logic                     blank_reg;
`endif

  // Snapshot viewed as a 4-entry array so the 2-bit scan index never leaves range.
  logic [SCORE_W-1:0] score_arr [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_score
    if (gi < NUM_P) begin : g_used
      assign score_arr[gi] = snap_reg[gi*SCORE_W +: SCORE_W];
    end else begin : g_unused
      assign score_arr[gi] = '0;
    end
  end

  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W-1:0] best_next;
  logic [1:0]         lead_next;
  logic               tie_next;

  always_comb begin
    cur_score = score_arr[idx_reg];
    best_next = best_reg;
    lead_next = lead_reg;
    tie_next  = tie_scan_reg;
    if (cur_score > best_reg) begin
      best_next = cur_score;
      lead_next = idx_reg;
      tie_next  = 1'b0;
    end else if (cur_score == best_reg) begin
      tie_next  = 1'b1;
    end
  end

  // Glyphs are drawn active-high (row 0 in the top byte) and inverted for the matrix.
  function automatic logic [63:0] glyph_rows(input logic [1:0] w, input logic t);
    logic [63:0] pat;
    if (t) begin
      pat = 64'h0000_AE49_49AE_0000;
    end else begin
      case (w)
        2'd0:    pat = 64'h0010_3010_1010_7C00;
        2'd1:    pat = 64'h003C_4204_1820_7E00;
        2'd2:    pat = 64'h003C_420C_0242_3C00;
        default: pat = 64'h000C_1424_7E04_0400;
      endcase
    end
    return ~pat;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      snap_reg     <= '0;
      best_reg     <= '0;
      lead_reg     <= '0;
      tie_scan_reg <= 1'b0;
      idx_reg      <= '0;
      tick_cnt_reg <= '0;
      winner_reg   <= '0;
      tie_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rows_reg     <= '1;
`ifdef CC_RACE_JUDGE_BLINK_EN
      blink_cnt_reg <= '0;
      blank_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (CC_RACE_JUDGE_Start_In) begin
            snap_reg     <= CC_RACE_JUDGE_Scores_In;
            best_reg     <= CC_RACE_JUDGE_Scores_In[SCORE_W-1:0];
            lead_reg     <= '0;
            tie_scan_reg <= 1'b0;
            idx_reg      <= 2'd1;
            busy_reg     <= 1'b1;
            state_reg    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          best_reg     <= best_next;
          lead_reg     <= lead_next;
          tie_scan_reg <= tie_next;
          idx_reg      <= idx_reg + 2'd1;
          if (idx_reg == LAST_IDX) begin
            winner_reg   <= lead_next;
            tie_reg      <= tie_next;
            tick_cnt_reg <= '0;
            rows_reg     <= glyph_rows(lead_next, tie_next);
            state_reg    <= ST_SHOW;
`ifdef CC_RACE_JUDGE_BLINK_EN
            blink_cnt_reg <= '0;
            blank_reg     <= 1'b0;
`endif
          end
        end
        ST_SHOW: begin
          if (CC_RACE_JUDGE_Tick_In) begin
            if (tick_cnt_reg == HOLD_LAST) begin
              tick_cnt_reg <= '0;
              rows_reg     <= '1;
              done_reg     <= 1'b1;
              state_reg    <= ST_DONE;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
`ifdef CC_RACE_JUDGE_BLINK_EN
              // Each blink half-period ends by flipping between glyph and blank.
              if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg <= '0;
                blank_reg     <= ~blank_reg;
                rows_reg      <= blank_reg ? glyph_rows(winner_reg, tie_reg) : '1;
              end else begin
                blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
              end
`endif
            end
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign CC_RACE_JUDGE_D0_outBus  = rows_reg[63:56];
  assign CC_RACE_JUDGE_D1_outBus  = rows_reg[55:48];
  assign CC_RACE_JUDGE_D2_outBus  = rows_reg[47:40];
  assign CC_RACE_JUDGE_D3_outBus  = rows_reg[39:32];
  assign CC_RACE_JUDGE_D4_outBus  = rows_reg[31:24];
  assign CC_RACE_JUDGE_D5_outBus  = rows_reg[23:16];
  assign CC_RACE_JUDGE_D6_outBus  = rows_reg[15:8];
  assign CC_RACE_JUDGE_D7_outBus  = rows_reg[7:0];
  assign CC_RACE_JUDGE_Winner_Out = winner_reg;
  assign CC_RACE_JUDGE_Tie_Out    = tie_reg;
  assign CC_RACE_JUDGE_Busy_Out   = busy_reg;
  assign CC_RACE_JUDGE_Done_Out   = done_reg;

endmodule

// File: tb/tb_cc_race_judge.sv
// Directed bench for cc_race_judge: a 2-player and a 4-player instance share clock and reset.
module tb_cc_race_judge;

  localparam logic [63:0] G_P1  = 64'hFFEF_CFEF_EFEF_83FF;
  localparam logic [63:0] G_P2  = 64'hFFC3_BDFB_E7DF_81FF;
  localparam logic [63:0] G_P3  = 64'hFFC3_BDF3_FDBD_C3FF;
  localparam logic [63:0] G_P4  = 64'hFFF3_EBDB_81FB_FBFF;
  localparam logic [63:0] G_TIE = 64'hFFFF_51B6_B651_FFFF;
  localparam logic [63:0] BLANK = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start2, tick2, start4, tick4;
  logic [11:0] scores2;
  logic [23:0] scores4;

  logic [7:0]  a0, a1, a2, a3, a4, a5, a6, a7;
  logic [7:0]  b0, b1, b2, b3, b4, b5, b6, b7;
  logic [1:0]  winner2, winner4;
  logic        tie2, tie4, busy2, busy4, done2, done4;
  logic [63:0] rows2, rows4;
  assign rows2 = {a0, a1, a2, a3, a4, a5, a6, a7};
  assign rows4 = {b0, b1, b2, b3, b4, b5, b6, b7};

  int checks   = 0;
  int failures = 0;

  cc_race_judge #(.NUM_P(2)) u_dut2 (
    .CC_RACE_JUDGE_CLOCK_50   (clk),
    .CC_RACE_JUDGE_RESET_InLow(rst_n),
    .CC_RACE_JUDGE_Start_In   (start2),
    .CC_RACE_JUDGE_Tick_In    (tick2),
    .CC_RACE_JUDGE_Scores_In  (scores2),
    .CC_RACE_JUDGE_D0_outBus  (a0),
    .CC_RACE_JUDGE_D1_outBus  (a1),
    .CC_RACE_JUDGE_D2_outBus  (a2),
    .CC_RACE_JUDGE_D3_outBus  (a3),
    .CC_RACE_JUDGE_D4_outBus  (a4),
    .CC_RACE_JUDGE_D5_outBus  (a5),
    .CC_RACE_JUDGE_D6_outBus  (a6),
    .CC_RACE_JUDGE_D7_outBus  (a7),
    .CC_RACE_JUDGE_Winner_Out (winner2),
    .CC_RACE_JUDGE_Tie_Out    (tie2),
    .CC_RACE_JUDGE_Busy_Out   (busy2),
    .CC_RACE_JUDGE_Done_Out   (done2)
  );

  cc_race_judge #(.NUM_P(4)) u_dut4 (
    .CC_RACE_JUDGE_CLOCK_50   (clk),
    .CC_RACE_JUDGE_RESET_InLow(rst_n),
    .CC_RACE_JUDGE_Start_In   (start4),
    .CC_RACE_JUDGE_Tick_In    (tick4),
    .CC_RACE_JUDGE_Scores_In  (scores4),
    .CC_RACE_JUDGE_D0_outBus  (b0),
    .CC_RACE_JUDGE_D1_outBus  (b1),
    .CC_RACE_JUDGE_D2_outBus  (b2),
    .CC_RACE_JUDGE_D3_outBus  (b3),
    .CC_RACE_JUDGE_D4_outBus  (b4),
    .CC_RACE_JUDGE_D5_outBus  (b5),
    .CC_RACE_JUDGE_D6_outBus  (b6),
    .CC_RACE_JUDGE_D7_outBus  (b7),
    .CC_RACE_JUDGE_Winner_Out (winner4),
    .CC_RACE_JUDGE_Tie_Out    (tie4),
    .CC_RACE_JUDGE_Busy_Out   (busy4),
    .CC_RACE_JUDGE_Done_Out   (done4)
  );

  // Expected rows after n ticks of SHOW (blink half-period of 2 ticks when enabled).
  function automatic logic [63:0] show_exp(input logic [63:0] g, input int n);
`ifdef CC_RACE_JUDGE_BLINK_EN
    return (((n / 2) % 2) == 1) ? BLANK : g;
`else
    return g;
`endif
  endfunction

  task automatic start2_pulse(input logic [11:0] s);
    @(negedge clk); scores2 = s; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
  endtask

  task automatic start4_pulse(input logic [23:0] s);
    @(negedge clk); scores4 = s; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
  endtask

  task automatic tick2_pulse();
    @(negedge clk); tick2 = 1'b1;
    @(negedge clk); tick2 = 1'b0;
  endtask

  task automatic tick4_pulse();
    @(negedge clk); tick4 = 1'b1;
    @(negedge clk); tick4 = 1'b0;
  endtask

  task automatic finish2();
    repeat (8) tick2_pulse();
    @(negedge clk);
  endtask

  task automatic finish4();
    repeat (8) tick4_pulse();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start2 = 0; tick2 = 0; start4 = 0; tick4 = 0; scores2 = '0; scores4 = '0;
    #12;
    checks++; if (rows2 !== BLANK) begin failures++; $display("FAIL reset_rows2 got=%h exp=%h", rows2, BLANK); end
    checks++; if (rows4 !== BLANK) begin failures++; $display("FAIL reset_rows4 got=%h exp=%h", rows4, BLANK); end
    checks++; if ({winner2, tie2, busy2, done2} !== 5'b0) begin failures++; $display("FAIL reset_flags2 got=%b exp=00000", {winner2, tie2, busy2, done2}); end
    checks++; if ({winner4, tie4, busy4, done4} !== 5'b0) begin failures++; $display("FAIL reset_flags4 got=%b exp=00000", {winner4, tie4, busy4, done4}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy2); end
  endtask

  task automatic test_p1_win();
    int i;
    start2_pulse({6'd10, 6'd20});
    checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL p1_scan_busy got=%b exp=1", busy2); end
    checks++; if (rows2 !== BLANK) begin failures++; $display("FAIL p1_scan_rows got=%h exp=%h", rows2, BLANK); end
    @(negedge clk);
    checks++; if (winner2 !== 2'd0) begin failures++; $display("FAIL p1_winner got=%0d exp=0", winner2); end
    checks++; if (tie2 !== 1'b0) begin failures++; $display("FAIL p1_tie got=%b exp=0", tie2); end
    checks++; if (a1 !== 8'hEF) begin failures++; $display("FAIL p1_d1 got=%h exp=ef", a1); end
    checks++; if (rows2 !== G_P1) begin failures++; $display("FAIL p1_rows got=%h exp=%h", rows2, G_P1); end
    for (i = 1; i <= 8; i++) begin
      tick2_pulse();
      if (i < 8) begin
        checks++; if (rows2 !== show_exp(G_P1, i)) begin failures++; $display("FAIL p1_show_rows tick=%0d got=%h exp=%h", i, rows2, show_exp(G_P1, i)); end
        checks++; if (done2 !== 1'b0) begin failures++; $display("FAIL p1_early_done tick=%0d got=%b exp=0", i, done2); end
      end else begin
        checks++; if (done2 !== 1'b1) begin failures++; $display("FAIL p1_done got=%b exp=1", done2); end
        checks++; if (rows2 !== BLANK) begin failures++; $display("FAIL p1_done_rows got=%h exp=%h", rows2, BLANK); end
      end
    end
    @(negedge clk);
    checks++; if ({busy2, done2} !== 2'b00) begin failures++; $display("FAIL p1_idle busy_done got=%b exp=00", {busy2, done2}); end
    checks++; if (winner2 !== 2'd0) begin failures++; $display("FAIL p1_winner_hold got=%0d exp=0", winner2); end
  endtask

  task automatic test_p2_win();
    start2_pulse({6'd33, 6'd5});
    @(negedge clk);
    checks++; if (winner2 !== 2'd1) begin failures++; $display("FAIL p2_winner got=%0d exp=1", winner2); end
    checks++; if (a6 !== 8'h81) begin failures++; $display("FAIL p2_d6 got=%h exp=81", a6); end
    checks++; if (rows2 !== G_P2) begin failures++; $display("FAIL p2_rows got=%h exp=%h", rows2, G_P2); end
    finish2();
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL p2_idle got=%b exp=0", busy2); end
  endtask

  task automatic test_start_tick_together();
    @(negedge clk); scores2 = {6'd32, 6'd31}; start2 = 1'b1; tick2 = 1'b1;
    @(negedge clk); start2 = 1'b0; tick2 = 1'b0;
    checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL st_tk_busy got=%b exp=1", busy2); end
    @(negedge clk);
    checks++; if (winner2 !== 2'd1) begin failures++; $display("FAIL unsigned_winner got=%0d exp=1", winner2); end
    checks++; if (rows2 !== G_P2) begin failures++; $display("FAIL unsigned_rows got=%h exp=%h", rows2, G_P2); end
    finish2();
  endtask

  task automatic test_snapshot();
    int i;
    int done_cnt;
    done_cnt = 0;
    start2_pulse({6'd10, 6'd20});
    scores2 = {6'd50, 6'd0}; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    checks++; if (winner2 !== 2'd0) begin failures++; $display("FAIL snap_winner got=%0d exp=0", winner2); end
    checks++; if (rows2 !== G_P1) begin failures++; $display("FAIL snap_rows got=%h exp=%h", rows2, G_P1); end
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    checks++; if ({busy2, done2} !== 2'b10) begin failures++; $display("FAIL show_start_ignored got=%b exp=10", {busy2, done2}); end
    checks++; if (rows2 !== G_P1) begin failures++; $display("FAIL show_start_rows got=%h exp=%h", rows2, G_P1); end
    for (i = 1; i <= 8; i++) begin
      tick2_pulse();
      if (done2 === 1'b1) done_cnt++;
    end
    @(negedge clk);
    if (done2 === 1'b1) done_cnt++;
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL snap_done_count got=%0d exp=1", done_cnt); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL snap_idle got=%b exp=0", busy2); end
    tick2_pulse();
    checks++; if ({busy2, done2} !== 2'b00) begin failures++; $display("FAIL idle_tick_ignored got=%b exp=00", {busy2, done2}); end
    checks++; if (rows2 !== BLANK) begin failures++; $display("FAIL idle_tick_rows got=%h exp=%h", rows2, BLANK); end
  endtask

  task automatic test_reset_mid_show();
    start2_pulse({6'd33, 6'd5});
    @(negedge clk);
    repeat (4) tick2_pulse();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rows2 !== BLANK) begin failures++; $display("FAIL rst_show_rows got=%h exp=%h", rows2, BLANK); end
    checks++; if ({winner2, tie2, busy2, done2} !== 5'b0) begin failures++; $display("FAIL rst_show_flags got=%b exp=00000", {winner2, tie2, busy2, done2}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy2, done2} !== 2'b00) begin failures++; $display("FAIL rst_no_done got=%b exp=00", {busy2, done2}); end
    start2_pulse({6'd33, 6'd5});
    @(negedge clk);
    checks++; if (winner2 !== 2'd1) begin failures++; $display("FAIL rst_fresh_winner got=%0d exp=1", winner2); end
    checks++; if (rows2 !== G_P2) begin failures++; $display("FAIL rst_fresh_rows got=%h exp=%h", rows2, G_P2); end
    finish2();
  endtask

  task automatic test_tie4();
    start4_pulse({6'd12, 6'd40, 6'd40, 6'd7});
    @(negedge clk);
    @(negedge clk);
    checks++; if ({busy4, rows4} !== {1'b1, BLANK}) begin failures++; $display("FAIL tie4_scan got=%b/%h exp=1/%h", busy4, rows4, BLANK); end
    @(negedge clk);
    checks++; if (tie4 !== 1'b1) begin failures++; $display("FAIL tie4_tie got=%b exp=1", tie4); end
    checks++; if (winner4 !== 2'd1) begin failures++; $display("FAIL tie4_winner got=%0d exp=1", winner4); end
    checks++; if (b2 !== 8'h51) begin failures++; $display("FAIL tie4_d2 got=%h exp=51", b2); end
    checks++; if (rows4 !== G_TIE) begin failures++; $display("FAIL tie4_rows got=%h exp=%h", rows4, G_TIE); end
    finish4();
    checks++; if ({busy4, tie4} !== 2'b01) begin failures++; $display("FAIL tie4_hold got=%b exp=01", {busy4, tie4}); end
  endtask

  task automatic test_tie_cleared();
    start4_pulse({6'd1, 6'd63, 6'd40, 6'd40});
    checks++; if (tie4 !== 1'b1) begin failures++; $display("FAIL tie_hold_scan got=%b exp=1", tie4); end
    repeat (3) @(negedge clk);
    checks++; if (winner4 !== 2'd2) begin failures++; $display("FAIL clr_winner got=%0d exp=2", winner4); end
    checks++; if (tie4 !== 1'b0) begin failures++; $display("FAIL clr_tie got=%b exp=0", tie4); end
    checks++; if (rows4 !== G_P3) begin failures++; $display("FAIL clr_rows got=%h exp=%h", rows4, G_P3); end
    finish4();
  endtask

  task automatic test_p4();
    start4_pulse({6'd50, 6'd49, 6'd0, 6'd49});
    repeat (3) @(negedge clk);
    checks++; if ({winner4, tie4} !== 3'b110) begin failures++; $display("FAIL p4_result got=%b exp=110", {winner4, tie4}); end
    checks++; if (rows4 !== G_P4) begin failures++; $display("FAIL p4_rows got=%h exp=%h", rows4, G_P4); end
    finish4();
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL p4_idle got=%b exp=0", busy4); end
  endtask

  initial begin
    test_reset();
    test_p1_win();
    test_p2_win();
    test_start_tick_together();
    test_snapshot();
    test_reset_mid_show();
    test_tie4();
    test_tie_cleared();
    test_p4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_race_judge.md
CC_RACE_JUDGE -- requirements
Module: cc_race_judge

Interface
REQ-001 Parameter NUM_P, default 2, number of players compared; legal range 2..4.
REQ-002 Parameter SCORE_W, default 6, width of each player score in bits.
REQ-003 Parameter HOLD_TICKS, default 8, number of frame ticks the result stays displayed.
REQ-004 Parameter BLINK_TICKS, default 2, frame ticks per blink half-period; used only with the blink feature.
REQ-005 CC_RACE_JUDGE_CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-006 CC_RACE_JUDGE_RESET_InLow  in  1  reset, asynchronous, active-low.
REQ-007 CC_RACE_JUDGE_Start_In  in  1  one-cycle race-end strobe.
REQ-008 CC_RACE_JUDGE_Tick_In  in  1  one-cycle frame tick.
REQ-009 CC_RACE_JUDGE_Scores_In  in  NUM_P*SCORE_W  packed scores; player k occupies bits [k*SCORE_W +: SCORE_W].
REQ-010 CC_RACE_JUDGE_D0_outBus..D7_outBus  out  8 each  matrix rows 0..7, active-low (0 = LED on).
REQ-011 CC_RACE_JUDGE_Winner_Out  out  2  index of the winning player, registered.
REQ-012 CC_RACE_JUDGE_Tie_Out  out  1  the maximum score is shared, registered.
REQ-013 CC_RACE_JUDGE_Busy_Out  out  1  high in every state except IDLE.
REQ-014 CC_RACE_JUDGE_Done_Out  out  1  one-cycle pulse when the display period ends.

Function
REQ-015 FSM states SHALL be IDLE, SCAN, SHOW and DONE.
REQ-016 IDLE: Start high SHALL snapshot Scores_In into an internal register, load best=player 0, tie=0, scan index=1, and go to SCAN.
REQ-017 SCAN: each cycle, player[index] > best SHALL replace best and winner and clear tie; an equal score SHALL set tie; a smaller score SHALL change nothing.
REQ-018 The index SHALL increment in SCAN; after index NUM_P-1 is compared, the FSM SHALL enter SHOW, giving NUM_P cycles from Start to SHOW.
REQ-019 A tie flag set by one score SHALL be cleared by any later strictly greater score.
REQ-020 Comparisons SHALL be unsigned, full SCORE_W width; scores in the snapshot SHALL be used, not live inputs.
REQ-021 On SHOW entry, Winner_Out and Tie_Out SHALL update and the tick counter SHALL clear.
REQ-022 SHOW SHALL drive the glyph for the winner, or the tie glyph when Tie_Out=1.
REQ-023 Glyph rows D0..D7, given as active-high hex with output equal to their bitwise inverse:
  P1 00 10 30 10 10 10 7C 00
  P2 00 3C 42 04 18 20 7E 00
  P3 00 3C 42 0C 02 42 3C 00
  P4 00 0C 14 24 7E 04 04 00
  TIE 00 00 AE 49 49 AE 00 00
REQ-024 SHOW SHALL count Tick pulses; on the HOLD_TICKS-th tick it SHALL enter DONE.
REQ-025 DONE SHALL last one cycle with Done_Out=1 and then return to IDLE; Winner_Out and Tie_Out SHALL hold their values until the next SHOW entry.
REQ-026 In IDLE, SCAN and DONE, all rows SHALL be 8'hFF (blank).
REQ-027 Start SHALL be ignored in SCAN, SHOW and DONE.
REQ-028 Tick SHALL be ignored outside SHOW.
REQ-029 Start and Tick asserted together in IDLE SHALL start a scan.

Reset
REQ-030 While RESET_InLow=0, the block SHALL be asynchronously forced to: state IDLE, rows 8'hFF, Winner_Out 0, Tie_Out 0, Busy_Out 0, Done_Out 0, counters and snapshot 0.
REQ-031 Reset asserted in any state, including mid-SCAN or mid-SHOW, SHALL abort the operation with no Done pulse.
REQ-032 Operation SHALL resume on the first rising clock edge after reset is released.

Configuration
REQ-033 With macro CC_RACE_JUDGE_BLINK_EN defined, SHOW SHALL alternate glyph / blank (8'hFF) every BLINK_TICKS ticks, starting with the glyph; the hold count SHALL be unaffected.
REQ-034 Without CC_RACE_JUDGE_BLINK_EN, the glyph SHALL be steady for all of SHOW and no blink counter SHALL be synthesised.

Verification
REQ-035 NUM_P=2, scores 20/10, Start -> after 2 cycles Winner=0, Tie=0, P1 glyph (D1=8'hEF); 8 ticks later Done pulses once and rows return to 8'hFF.
REQ-036 NUM_P=2, scores 5/33 -> Winner=1, P2 glyph (D6=8'h81).
REQ-037 NUM_P=4, scores 7,40,40,12 -> Tie=1, tie glyph (D2=8'h51); scores 40,40,63,1 -> Winner=2, Tie=0, P3 glyph.
REQ-038 Change scores and pulse Start during SCAN -> result uses the original snapshot and the second Start is ignored.
REQ-039 Reset at tick 4 of SHOW -> rows 8'hFF and Busy=0 immediately, no Done pulse; a fresh Start works normally.
REQ-040 BLINK_EN, BLINK_TICKS=2 -> rows glyph, glyph, blank, blank, glyph... per tick; Done still after 8 ticks.
